// File: rtl/antilog_pkg.sv
// antilog_pkg: shared widths, saturation constant and FSM state type for the antilog block
package antilog_pkg;
    localparam int LOG_W  = 16;
    localparam int LIN_W  = 46;
    localparam int FRAC_W = 9;
    localparam int K_W    = LOG_W - FRAC_W;
    localparam int K_MAX  = 44;
    localparam logic [LIN_W-1:0] SAT_VAL = 46'h1FFF_FFFF_FFFF;
    typedef enum logic {IDLE, CALC} state_t;
endpackage

// File: rtl/antilog_shl46.sv
// antilog_shl46: barrel shifter placing the 1.f mantissa at binary point k (left for k>=9, truncating right otherwise)
module antilog_shl46
    import antilog_pkg::*;
(
    input  logic [FRAC_W:0]  m_i,
    input  logic [K_W-1:0]   k_i,
    output logic [LIN_W-1:0] sh_o
);
    logic [LIN_W-1:0] ext;
    assign ext = {{(LIN_W-FRAC_W-1){1'b0}}, m_i};
    // k equal to the fraction width is the identity point of the mantissa
    always_comb sh_o = (k_i >= K_W'(FRAC_W)) ? ext << (k_i - K_W'(FRAC_W)) : ext >> (K_W'(FRAC_W) - k_i);
endmodule

// File: rtl/antilog.sv
// antilog: two-cycle log2-to-linear converter with zero marker and saturation above 2^44
module antilog
    import antilog_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [LOG_W-1:0] in,
    input  logic             zero,
    output logic [LIN_W-1:0] out,
    output logic             overf,
    output logic             done,
    output logic             busy
);
    state_t           state_q;
    logic [LOG_W-1:0] in_q;
    logic             zero_q;
    logic [LIN_W-1:0] out_q, out_d, sh;
    logic             overf_q, overf_d, done_q;
    logic [K_W-1:0]   k;
    assign k = in_q[LOG_W-1:FRAC_W];
    antilog_shl46 u_shl (
        .m_i  ({1'b1, in_q[FRAC_W-1:0]}),
        .k_i  (k),
        .sh_o (sh)
    );
    // zero marker dominates saturation, which dominates the shifted mantissa
    always_comb begin
        overf_d = !zero_q && (k > K_W'(K_MAX));
        out_d   = zero_q ? '0 : (overf_d ? SAT_VAL : sh);
    end
    // control FSM: capture in IDLE, load result and pulse done in CALC
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            in_q    <= '0;
            zero_q  <= 1'b0;
            out_q   <= '0;
            overf_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (state_q == IDLE) begin
            done_q <= 1'b0;
            if (en) begin
                in_q    <= in;
                zero_q  <= zero;
                state_q <= CALC;
            end
        end else begin
            out_q   <= out_d;
            overf_q <= overf_d;
            done_q  <= 1'b1;
            state_q <= IDLE;
        end
    end
    assign out   = out_q;
    assign overf = overf_q;
    assign done  = done_q;
    assign busy  = (state_q == CALC);
endmodule

// File: tb/tb_antilog.sv
// tb_antilog: directed self-checking bench for antilog
module tb_antilog;
    logic        clk, reset, en, zero, overf, done, busy;
    logic [15:0] in;
    logic [45:0] out;
    int n_checks = 0;
    int n_fail   = 0;

    localparam int NV = 11;
    localparam logic [15:0] VIN [NV] = '{16'h1200, 16'h1300, 16'h0000, 16'h0300, 16'h5800,
                                         16'h5A00, 16'h7FFF, 16'h0A00, 16'h1201, 16'h0BFF, 16'h5A00};
    localparam logic        VZ  [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    localparam logic [45:0] VOUT[NV] = '{46'd512, 46'd768, 46'd1, 46'd3, 46'h1000_0000_0000,
                                         46'h1FFF_FFFF_FFFF, 46'h1FFF_FFFF_FFFF, 46'd32, 46'd513, 46'd63, 46'd0};
    localparam logic        VOV [NV] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};

    antilog dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .in    (in),
        .zero  (zero),
        .out   (out),
        .overf (overf),
        .done  (done),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // issue one request from a negedge; returns busy after the capture edge and outputs after the result edge
    task automatic do_req(input logic [15:0] v, input logic z, output logic b, output logic d,
                          output logic [45:0] o, output logic ov);
        in = v; zero = z; en = 1'b1;
        @(negedge clk);
        b = busy; en = 1'b0;
        @(negedge clk);
        d = done; o = out; ov = overf;
    endtask

    task automatic test_reset;
        reset = 1'b0; en = 1'b1; in = 16'h5A00; zero = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out, overf, done, busy} !== 49'd0) begin
            n_fail++; $display("FAIL reset_state out=%h overf=%b done=%b busy=%b required all 0", out, overf, done, busy);
        end
        in = 16'h1200; reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL first_accept busy=%b done=%b required busy=1 done=0", busy, done);
        end
        en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || out !== 46'd512 || overf !== 1'b0) begin
            n_fail++; $display("FAIL first_result done=%b out=%h overf=%b required 1 200 0", done, out, overf);
        end
        @(negedge clk);
    endtask

    task automatic test_vectors;
        logic b, d, ov;
        logic [45:0] o;
        for (int i = 0; i < NV; i++) begin
            do_req(VIN[i], VZ[i], b, d, o, ov);
            n_checks++;
            if (b !== 1'b1 || d !== 1'b1 || o !== VOUT[i] || ov !== VOV[i]) begin
                n_fail++;
                $display("FAIL vec%0d in=%h zero=%b busy=%b done=%b out=%h overf=%b required busy=1 done=1 out=%h overf=%b",
                         i, VIN[i], VZ[i], b, d, o, ov, VOUT[i], VOV[i]);
            end
            in = ~VIN[i];
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || out !== VOUT[i] || overf !== VOV[i]) begin
                n_fail++;
                $display("FAIL hold%0d done=%b busy=%b out=%h overf=%b required 0 0 %h %b", i, done, busy, out, overf, VOUT[i], VOV[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int dones = 0;
        en = 1'b1; zero = 1'b0; in = 16'h1300;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (done) dones++;
            n_checks++;
            if (busy !== logic'(c % 2) || done !== logic'(1 - c % 2)) begin
                n_fail++; $display("FAIL b2b_cycle%0d busy=%b done=%b required busy=%0d done=%0d", c, busy, done, c % 2, 1 - c % 2);
            end
        end
        en = 1'b0;
        n_checks++;
        if (dones !== 4 || out !== 46'd768) begin
            n_fail++; $display("FAIL b2b_total dones=%0d out=%h required 4 300", dones, out);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_calc;
        logic b, d, ov;
        logic [45:0] o;
        in = 16'h5800; zero = 1'b0; en = 1'b1;
        @(negedge clk);
        en = 1'b0; reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || out !== 46'd0 || busy !== 1'b0 || overf !== 1'b0) begin
            n_fail++; $display("FAIL abort done=%b out=%h busy=%b overf=%b required 0 0 0 0", done, out, busy, overf);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_done done=%b busy=%b required 0 0", done, busy);
        end
        do_req(16'h0300, 1'b0, b, d, o, ov);
        n_checks++;
        if (d !== 1'b1 || o !== 46'd3 || ov !== 1'b0) begin
            n_fail++; $display("FAIL post_abort done=%b out=%h overf=%b required 1 3 0", d, o, ov);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; in = '0; zero = 1'b0;
        @(negedge clk);
        test_reset;
        test_vectors;
        test_back_to_back;
        test_reset_calc;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/antilog.md
ANTILOG -- requirements
Module: antilog

Interface
REQ-001 Parameters: none; all widths fixed by package constants.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low; sampled on rising edge of clk.
REQ-004 en  input  1  request strobe; sampled only in IDLE.
REQ-005 in  input  16  log-domain value, in = log2(x)*512; in[15:9] = integer part k, in[8:0] = fraction f.
REQ-006 zero  input  1  end-of-speech/zero marker, sampled with en; forces result 0.
REQ-007 out  output  46  linear-domain result; out[45] always 0.
REQ-008 overf  output  1  result saturated (k > 44); valid with done.
REQ-009 done  output  1  one-cycle pulse: out/overf updated this cycle.
REQ-010 busy  output  1  high while state != IDLE.

Function
REQ-011 FSM states IDLE, CALC; reset state IDLE.
REQ-012 IDLE: en=1 -> capture in, zero into internal registers, go CALC; en=0 -> stay IDLE.
REQ-013 CALC: compute, load out/overf, assert done for exactly one cycle, return to IDLE unconditionally.
REQ-014 Latency: en sampled at edge N -> out, overf, done visible after edge N+1; throughput one request per 2 cycles.
REQ-015 en in CALC ignored (no queuing); caller observes busy.
REQ-016 Mantissa m = {1'b1, f} (10 bits, value 1.f).
REQ-017 k >= 9: out = m << (k-9), zero-extended to 46 bits.
REQ-018 k < 9: out = m >> (9-k), fraction bits truncated (no rounding); k=0 -> out=1.
REQ-019 k in 45..127: out = 46'h1FFF_FFFF_FFFF (bits 44:0 set), overf=1.
REQ-020 zero=1: out = 0, overf = 0, regardless of in.
REQ-021 Otherwise overf = 0 with each done.
REQ-022 out and overf hold their values between done pulses; done low otherwise.
REQ-023 Mitchell approximation: REQ-016..018 exactly invert the linear-fraction log encoding of the energy path; no correction term.

Reset
REQ-024 reset=0 at any edge: state IDLE, out=0, overf=0, done=0, busy=0, captured registers cleared.
REQ-025 Reset asserted during CALC aborts the request; no done pulse for it after reset release.
REQ-026 First en accepted on the first edge with reset=1.

Structure
REQ-027 Shared package holds LOG_W=16, LIN_W=46, FRAC_W=9, K_MAX=44, SAT_VAL, and the state enum.
REQ-028 One sub-module natural: shl46, combinational 10-bit-in/46-bit-out left/right barrel shifter driven by k; FSM and saturation logic stay in antilog.
REQ-029 Shifter output registered only in CALC; no combinational path from in to out.

Verification
REQ-030 in=16'h1200, zero=0, en pulse -> done two edges later, out=512, overf=0.
REQ-031 in=16'h1300 -> out=768; in=16'h0000 -> out=1; in=16'h0300 (k=1, f=0x100) -> out=3.
REQ-032 in=16'h5800 -> out=2^44 (46'h1000_0000_0000), overf=0; in=16'h5A00 -> out=46'h1FFF_FFFF_FFFF, overf=1.
REQ-033 zero=1, in=16'h5A00 -> out=0, overf=0, done pulse.
REQ-034 en held high continuously -> one done every 2 cycles, busy toggles 1/0; en during CALC produces no extra done.
REQ-035 reset=0 during CALC -> no done, out=0, busy=0 next cycle; subsequent en yields correct result.
